// File: rtl/wb_slave_pkg.sv
// Shared widths and FSM state encoding for the Wishbone memory slave.
package wb_slave_pkg;

    localparam int unsigned WB_DW   = 32;
    localparam int unsigned WB_AW   = 32;
    localparam int unsigned WB_SELW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } wb_slv_state_e;

endpackage

// File: rtl/wb_slave_mem.sv
// Single-port word RAM with per-byte write enables, synchronous write and
// combinational read.
module wb_slave_mem
    import wb_slave_pkg::*;
#(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [WB_SELW-1:0] i_sel,
    input  logic [AW-1:0]      i_idx,
    input  logic [WB_DW-1:0]   i_wdata,
    output logic [WB_DW-1:0]   o_rdata
);

    logic [WB_DW-1:0] r_mem [WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int unsigned b = 0; b < WB_SELW; b++) begin
                if (i_sel[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/wb_slave_behavioral.sv
// Wishbone B3 classic-cycle memory slave: address window decode, programmable
// wait states, byte-lane writes and ERR termination on a window miss.
module wb_slave_behavioral
    import wb_slave_pkg::*;
#(
    parameter logic [WB_AW-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [WB_AW-1:0] ADDR_MASK   = 32'hFFFF_F000,
    parameter int unsigned      MEM_WORDS   = 1024,
    parameter int unsigned      WAIT_STATES = 1
) (
    input  logic               CLK_I,
    input  logic               RST_N_I,
    input  logic [WB_AW-1:0]   ADR_I,
    input  logic [WB_DW-1:0]   DAT_I,
    input  logic [WB_SELW-1:0] SEL_I,
    input  logic               WE_I,
    input  logic               CYC_I,
    input  logic               STB_I,
    input  logic               CAB_I,
    output logic [WB_DW-1:0]   DAT_O,
    output logic               ACK_O,
    output logic               ERR_O,
    output logic               RTY_O
);

    localparam int unsigned AW      = $clog2(MEM_WORDS);
    localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES);

    wb_slv_state_e      r_state;
    wb_slv_state_e      w_state_nxt;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_nxt;
    logic [AW-1:0]      r_idx;
    logic [WB_DW-1:0]   r_dat;
    logic [WB_SELW-1:0] r_sel;
    logic               r_we;
    logic               r_hit;

    logic               w_req;
    logic [AW-1:0]      w_in_idx;
    logic               w_in_hit;
    logic               w_use_in;
    logic [AW-1:0]      w_idx;
    logic [WB_DW-1:0]   w_dat;
    logic [WB_SELW-1:0] w_sel;
    logic               w_we;
    logic               w_hit;
    logic               w_go_resp;
    logic               w_mem_we;
    logic [WB_DW-1:0]   w_rdata;
    logic               w_unused;

    // Burst hint is accepted but every access is a classic cycle.
    assign w_unused = CAB_I;
    assign RTY_O    = 1'b0;

    assign w_req    = CYC_I & STB_I;
    assign w_in_idx = ADR_I[AW+1:2];
    assign w_in_hit = ((ADR_I & ADDR_MASK) == (BASE_ADDR & ADDR_MASK))
                   && (32'(w_in_idx) < 32'(MEM_WORDS));

    // Zero-wait accesses respond straight from IDLE, so use the live bus there.
    assign w_use_in = (r_state == IDLE);
    assign w_idx    = w_use_in ? w_in_idx : r_idx;
    assign w_dat    = w_use_in ? DAT_I    : r_dat;
    assign w_sel    = w_use_in ? SEL_I    : r_sel;
    assign w_we     = w_use_in ? WE_I     : r_we;
    assign w_hit    = w_use_in ? w_in_hit : r_hit;
    assign w_mem_we = w_go_resp & w_hit & w_we;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_go_resp   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (WAIT_STATES == 0) begin
                        w_state_nxt = RESP;
                        w_go_resp   = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = WS_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!w_req) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt <= 4'd1) begin
                    w_state_nxt = RESP;
                    w_cnt_nxt   = 4'd0;
                    w_go_resp   = 1'b1;
                end else begin
                    w_cnt_nxt   = 4'(r_cnt - 4'd1);
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_hit   <= 1'b0;
            ACK_O   <= 1'b0;
            ERR_O   <= 1'b0;
            DAT_O   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == IDLE && w_req) begin
                r_idx <= w_in_idx;
                r_dat <= DAT_I;
                r_sel <= SEL_I;
                r_we  <= WE_I;
                r_hit <= w_in_hit;
            end
            ACK_O <= w_go_resp & w_hit;
            ERR_O <= w_go_resp & ~w_hit;
            DAT_O <= (w_go_resp & w_hit & ~w_we) ? w_rdata : '0;
        end
    end

    wb_slave_mem #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_mem (
        .clk     (CLK_I),
        .i_we    (w_mem_we),
        .i_sel   (w_sel),
        .i_idx   (w_idx),
        .i_wdata (w_dat),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_wb_slave_behavioral.sv
// Directed bench for wb_slave_behavioral: one instance with one wait state and
// one with three, sharing the bus except for their own CYC/STB.
module tb_wb_slave_behavioral;

    logic        clk;
    logic        rst_n;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic        we;
    logic        cab;
    logic        cyc1, stb1, cyc3, stb3;
    logic [31:0] dat1, dat3;
    logic        ack1, err1, rty1, ack3, err3, rty3;

    int n_vec = 0;
    int n_err = 0;

    wb_slave_behavioral #(.WAIT_STATES(1)) dut1 (
        .CLK_I(clk), .RST_N_I(rst_n), .ADR_I(adr), .DAT_I(dat_w), .SEL_I(sel),
        .WE_I(we), .CYC_I(cyc1), .STB_I(stb1), .CAB_I(cab),
        .DAT_O(dat1), .ACK_O(ack1), .ERR_O(err1), .RTY_O(rty1)
    );

    wb_slave_behavioral #(.WAIT_STATES(3)) dut3 (
        .CLK_I(clk), .RST_N_I(rst_n), .ADR_I(adr), .DAT_I(dat_w), .SEL_I(sel),
        .WE_I(we), .CYC_I(cyc3), .STB_I(stb3), .CAB_I(cab),
        .DAT_O(dat3), .ACK_O(ack3), .ERR_O(err3), .RTY_O(rty3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One classic access; reports termination, data, latency and whether
    // anything was still driven one cycle after the termination.
    task automatic bus_xfer(input int which, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic w,
                            output logic o_ack, output logic o_err, output logic [31:0] o_dat,
                            output int o_lat, output logic o_tail);
        logic        k_ack, k_err;
        logic [31:0] k_dat;
        @(negedge clk);
        adr = a; dat_w = d; sel = s; we = w;
        if (which == 3) begin cyc3 = 1'b1; stb3 = 1'b1; end
        else            begin cyc1 = 1'b1; stb1 = 1'b1; end
        o_ack = 1'b0; o_err = 1'b0; o_dat = '0; o_lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            k_ack = (which == 3) ? ack3 : ack1;
            k_err = (which == 3) ? err3 : err1;
            k_dat = (which == 3) ? dat3 : dat1;
            if (k_ack || k_err) begin
                o_ack = k_ack; o_err = k_err; o_dat = k_dat; o_lat = i;
                break;
            end
        end
        cyc1 = 1'b0; stb1 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0;
        @(posedge clk); #1;
        k_ack = (which == 3) ? ack3 : ack1;
        k_err = (which == 3) ? err3 : err1;
        k_dat = (which == 3) ? dat3 : dat1;
        o_tail = k_ack | k_err | (|k_dat);
    endtask

    task automatic test_reset();
        logic spurious;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_vec++;
        if ({ack1, err1, rty1, ack3, err3, rty3} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags: got %b expected 000000", {ack1, err1, rty1, ack3, err3, rty3});
        end
        n_vec++;
        if ({dat1, dat3} !== 64'h0) begin
            n_err++; $display("FAIL reset_dat: got %h/%h expected 0/0", dat1, dat3);
        end
        @(negedge clk); rst_n = 1'b1;
        spurious = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            spurious = spurious | ack1 | err1 | ack3 | err3 | rty1 | rty3;
        end
        n_vec++;
        if (spurious !== 1'b0) begin
            n_err++; $display("FAIL reset_idle: got spurious=%b expected 0", spurious);
        end
    endtask

    task automatic test_write_read();
        logic a, e, t; logic [31:0] d; int lat;
        bus_xfer(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b1, a, e, d, lat, t);
        n_vec++;
        if ({a, e} !== 2'b10) begin n_err++; $display("FAIL wr_term: got ack/err=%b expected 10", {a, e}); end
        n_vec++;
        if (lat !== 2) begin n_err++; $display("FAIL wr_latency: got %0d expected 2", lat); end
        n_vec++;
        if (t !== 1'b0) begin n_err++; $display("FAIL wr_pulse: got tail=%b expected 0", t); end
        bus_xfer(1, 32'h0000_0010, 32'h0, 4'b1111, 1'b0, a, e, d, lat, t);
        n_vec++;
        if ({a, e, d} !== {2'b10, 32'hDEAD_BEEF}) begin
            n_err++; $display("FAIL rd_data: got ack/err=%b dat=%h expected 10 deadbeef", {a, e}, d);
        end
        n_vec++;
        if (lat !== 2 || t !== 1'b0) begin
            n_err++; $display("FAIL rd_timing: got lat=%0d tail=%b expected 2 0", lat, t);
        end
        bus_xfer(1, 32'h0000_0013, 32'h0, 4'b1111, 1'b0, a, e, d, lat, t);
        n_vec++;
        if (d !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_unaligned: got %h expected deadbeef", d); end
    endtask

    task automatic test_byte_lanes();
        logic a, e, t; logic [31:0] d; int lat;
        bus_xfer(1, 32'h0000_0020, 32'h1122_3344, 4'b1111, 1'b1, a, e, d, lat, t);
        bus_xfer(1, 32'h0000_0020, 32'hAA55_66BB, 4'b1001, 1'b1, a, e, d, lat, t);
        bus_xfer(1, 32'h0000_0020, 32'h0, 4'b1111, 1'b0, a, e, d, lat, t);
        n_vec++;
        if (d !== 32'hAA22_33BB) begin n_err++; $display("FAIL byte_lanes: got %h expected aa2233bb", d); end
        bus_xfer(1, 32'h0000_0010, 32'h0123_4567, 4'b0000, 1'b1, a, e, d, lat, t);
        n_vec++;
        if (a !== 1'b1) begin n_err++; $display("FAIL sel0_ack: got %b expected 1", a); end
        bus_xfer(1, 32'h0000_0010, 32'h0, 4'b1111, 1'b0, a, e, d, lat, t);
        n_vec++;
        if (d !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL sel0_nowrite: got %h expected deadbeef", d); end
    endtask

    task automatic test_back_to_back();
        logic a, e, t; logic [31:0] d; int lat;
        bus_xfer(1, 32'h0000_0FFC, 32'hC0FF_EE01, 4'b1111, 1'b1, a, e, d, lat, t);
        bus_xfer(1, 32'h0000_0FFC, 32'h0, 4'b1111, 1'b0, a, e, d, lat, t);
        n_vec++;
        if ({a, d} !== {1'b1, 32'hC0FF_EE01}) begin
            n_err++; $display("FAIL raw_last_word: got ack=%b dat=%h expected 1 c0ffee01", a, d);
        end
    endtask

    task automatic test_out_of_window();
        logic a, e, t; logic [31:0] d; int lat;
        bus_xfer(1, 32'h0000_0000, 32'h5A5A_0F0F, 4'b1111, 1'b1, a, e, d, lat, t);
        bus_xfer(1, 32'h0000_2000, 32'h0, 4'b1111, 1'b0, a, e, d, lat, t);
        n_vec++;
        if ({a, e, d} !== {2'b01, 32'h0}) begin
            n_err++; $display("FAIL oow_read: got ack/err=%b dat=%h expected 01 00000000", {a, e}, d);
        end
        n_vec++;
        if (lat !== 2 || t !== 1'b0) begin
            n_err++; $display("FAIL oow_timing: got lat=%0d tail=%b expected 2 0", lat, t);
        end
        bus_xfer(1, 32'h0000_2000, 32'hFFFF_FFFF, 4'b1111, 1'b1, a, e, d, lat, t);
        n_vec++;
        if ({a, e} !== 2'b01) begin n_err++; $display("FAIL oow_write: got ack/err=%b expected 01", {a, e}); end
        bus_xfer(1, 32'h0000_0000, 32'h0, 4'b1111, 1'b0, a, e, d, lat, t);
        n_vec++;
        if (d !== 32'h5A5A_0F0F) begin n_err++; $display("FAIL oow_nowrite: got %h expected 5a5a0f0f", d); end
    endtask

    task automatic test_abort();
        logic a, e, t, seen; logic [31:0] d; int lat;
        @(negedge clk);
        adr = 32'h0000_0040; sel = 4'b1111; we = 1'b0; cyc3 = 1'b1; stb3 = 1'b1;
        @(posedge clk); #1;
        stb3 = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            seen = seen | ack3 | err3;
        end
        cyc3 = 1'b0;
        n_vec++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL abort_noterm: got ack|err=%b expected 0", seen); end
        bus_xfer(3, 32'h0000_0040, 32'h1234_5678, 4'b1111, 1'b1, a, e, d, lat, t);
        n_vec++;
        if ({a, e} !== 2'b10 || lat !== 4) begin
            n_err++; $display("FAIL abort_next_wr: got ack/err=%b lat=%0d expected 10 4", {a, e}, lat);
        end
        bus_xfer(3, 32'h0000_0040, 32'h0, 4'b1111, 1'b0, a, e, d, lat, t);
        n_vec++;
        if (d !== 32'h1234_5678 || lat !== 4) begin
            n_err++; $display("FAIL abort_next_rd: got dat=%h lat=%0d expected 12345678 4", d, lat);
        end
    endtask

    task automatic test_reset_mid_access();
        logic a, e, t; logic [31:0] d; int lat; int got;
        @(negedge clk);
        adr = 32'h0000_0010; dat_w = 32'h0BAD_F00D; sel = 4'b1111; we = 1'b1;
        cyc1 = 1'b1; stb1 = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({ack1, err1, dat1} !== {2'b00, 32'h0}) begin
            n_err++; $display("FAIL rst_wait_out: got ack/err=%b dat=%h expected 00 0", {ack1, err1}, dat1);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); cyc1 = 1'b0; stb1 = 1'b0; rst_n = 1'b1;
        bus_xfer(1, 32'h0000_0010, 32'h0, 4'b1111, 1'b0, a, e, d, lat, t);
        n_vec++;
        if ({a, d} !== {1'b1, 32'hDEAD_BEEF} || lat !== 2) begin
            n_err++; $display("FAIL rst_write_dropped: got ack=%b dat=%h lat=%0d expected 1 deadbeef 2", a, d, lat);
        end
        // Reset during the ACK cycle must clear the outputs without a clock edge.
        @(negedge clk);
        adr = 32'h0000_0010; we = 1'b0; cyc1 = 1'b1; stb1 = 1'b1;
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            @(posedge clk); #1;
            if (ack1) got = 1;
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (got !== 1 || {ack1, dat1} !== {1'b0, 32'h0}) begin
            n_err++; $display("FAIL rst_resp_out: got seen=%0d ack=%b dat=%h expected 1 0 0", got, ack1, dat1);
        end
        @(negedge clk); cyc1 = 1'b0; stb1 = 1'b0; rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; adr = '0; dat_w = '0; sel = '0; we = 1'b0; cab = 1'b0;
        cyc1 = 1'b0; stb1 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0;
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_back_to_back();
        test_out_of_window();
        test_abort();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
